// File: rtl/vx_warp_ibuffer.sv
// vx_warp_ibuffer: per-warp instruction FIFOs between the uop sequencer and issue.
// One push per cycle into the FIFO selected by in_wid; one pop per cycle from the
// round-robin winner among non-empty warps. Order within a warp is preserved.
// A flush empties one warp at the next edge and hides it from arbitration that cycle.
// Optional feature macro: IBUF_BYPASS_EN -- when every FIFO is empty, the incoming
// instruction is presented to issue in the same cycle (zero-latency path).
module vx_warp_ibuffer #(
    parameter int NUM_WARPS = 4,
    parameter int DEPTH     = 4,
    parameter int DATAW     = 128,
    localparam int WID_W    = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WID_W-1:0]     in_wid,
    input  logic [DATAW-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WID_W-1:0]     out_wid,
    output logic [DATAW-1:0]     out_data,
    input  logic                 flush_valid,
    input  logic [WID_W-1:0]     flush_wid,
    output logic [NUM_WARPS-1:0] warp_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATAW-1:0]     mem_q    [NUM_WARPS][DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q [NUM_WARPS];
    logic [PTR_W-1:0]     rd_ptr_d [NUM_WARPS];
    logic [PTR_W-1:0]     wr_ptr_q [NUM_WARPS];
    logic [PTR_W-1:0]     wr_ptr_d [NUM_WARPS];
    logic [CNT_W-1:0]     cnt_q    [NUM_WARPS];
    logic [CNT_W-1:0]     cnt_d    [NUM_WARPS];
    logic [WID_W-1:0]     rr_q;
    logic [WID_W-1:0]     rr_d;

    logic [NUM_WARPS-1:0] elig_s;
    logic [NUM_WARPS-1:0] push_hit_s;
    logic [NUM_WARPS-1:0] pop_hit_s;
    logic                 found_s;
    logic [WID_W-1:0]     win_s;
    logic [WID_W-1:0]     idx_s;
    logic                 all_empty_s;
    logic                 in_flushed_s;
    logic                 byp_s;
    logic                 byp_take_s;
    logic                 push_s;
    logic                 pop_s;

    // Round-robin search for the first non-empty, non-flushed warp starting at rr_q.
    always_comb begin
        elig_s  = '0;
        found_s = 1'b0;
        win_s   = rr_q;
        idx_s   = rr_q;
        for (int w = 0; w < NUM_WARPS; w++) begin
            warp_empty[w] = (cnt_q[w] == CNT_W'(0));
            elig_s[w]     = (cnt_q[w] != CNT_W'(0)) && !(flush_valid && (flush_wid == WID_W'(w)));
        end
        all_empty_s = (warp_empty == {NUM_WARPS{1'b1}});
        for (int i = 0; i < NUM_WARPS; i++) begin
            // NUM_WARPS is a power of two, so the WID_W-bit sum wraps modulo NUM_WARPS.
            idx_s = rr_q + WID_W'(i);
            if (!found_s && elig_s[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Handshakes, output selection and the optional empty-buffer bypass.
    always_comb begin
        in_flushed_s = flush_valid && (flush_wid == in_wid);
        in_ready     = (cnt_q[in_wid] != CNT_W'(DEPTH)) && !in_flushed_s;
`ifdef IBUF_BYPASS_EN
        byp_s        = all_empty_s && in_valid && !in_flushed_s;
`else
        byp_s        = 1'b0;
`endif
        if (byp_s) begin
            out_valid = 1'b1;
            out_wid   = in_wid;
            out_data  = in_data;
        end else begin
            out_valid = found_s;
            out_wid   = win_s;
            out_data  = mem_q[win_s][rd_ptr_q[win_s]];
        end
        byp_take_s = byp_s && out_ready;
        pop_s      = found_s && out_ready && !byp_s;
        push_s     = in_valid && in_ready && !byp_take_s;
    end

    // Next-state pointers, counts and arbitration pointer.
    always_comb begin
        if (pop_s) begin
            rr_d = win_s + WID_W'(1);
        end else if (byp_take_s) begin
            rr_d = in_wid + WID_W'(1);
        end else begin
            rr_d = rr_q;
        end
        for (int w = 0; w < NUM_WARPS; w++) begin
            push_hit_s[w] = push_s && (in_wid == WID_W'(w));
            pop_hit_s[w]  = pop_s && (win_s == WID_W'(w));
            rd_ptr_d[w]   = rd_ptr_q[w];
            wr_ptr_d[w]   = wr_ptr_q[w];
            cnt_d[w]      = cnt_q[w];
            if (flush_valid && (flush_wid == WID_W'(w))) begin
                rd_ptr_d[w] = PTR_W'(0);
                wr_ptr_d[w] = PTR_W'(0);
                cnt_d[w]    = CNT_W'(0);
            end else begin
                if (push_hit_s[w]) begin
                    wr_ptr_d[w] = wr_ptr_q[w] + PTR_W'(1);
                end else begin
                    wr_ptr_d[w] = wr_ptr_q[w];
                end
                if (pop_hit_s[w]) begin
                    rd_ptr_d[w] = rd_ptr_q[w] + PTR_W'(1);
                end else begin
                    rd_ptr_d[w] = rd_ptr_q[w];
                end
                case ({push_hit_s[w], pop_hit_s[w]})
                    2'b10:   cnt_d[w] = cnt_q[w] + CNT_W'(1);
                    2'b01:   cnt_d[w] = cnt_q[w] - CNT_W'(1);
                    default: cnt_d[w] = cnt_q[w];
                endcase
            end
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= WID_W'(0);
            for (int w = 0; w < NUM_WARPS; w++) begin
                rd_ptr_q[w] <= PTR_W'(0);
                wr_ptr_q[w] <= PTR_W'(0);
                cnt_q[w]    <= CNT_W'(0);
            end
        end else begin
            rr_q <= rr_d;
            for (int w = 0; w < NUM_WARPS; w++) begin
                rd_ptr_q[w] <= rd_ptr_d[w];
                wr_ptr_q[w] <= wr_ptr_d[w];
                cnt_q[w]    <= cnt_d[w];
            end
        end
    end

    // Payload storage; contents are only meaningful below each warp's count.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_q[in_wid][wr_ptr_q[in_wid]] <= in_data;
        end
    end

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// Testbench for vx_warp_ibuffer: hand-written vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_vx_warp_ibuffer;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_wid;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_wid;
    logic [127:0] out_data;
    logic         flush_valid;
    logic [1:0]   flush_wid;
    logic [3:0]   warp_empty;

    int checks;
    int errors;

    // Reference model: one queue per warp plus the round-robin pointer.
    logic [127:0] mq [4][$];
    int           m_rr;

    vx_warp_ibuffer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_data(out_data),
        .flush_valid(flush_valid), .flush_wid(flush_wid), .warp_empty(warp_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           rst;
        bit           iv;
        logic [1:0]   iw;
        logic [127:0] id;
        bit           ordy;
        bit           byp;
        bit           eov;
        logic [1:0]   ewid;
        logic [127:0] edata;
        bit           eirdy;
        logic [3:0]   ewe;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit iv, logic [1:0] iw, logic [127:0] id, bit ordy, bit byp,
                                bit eov, logic [1:0] ewid, logic [127:0] edata, bit eirdy, logic [3:0] ewe);
        vec_t v;
        v.rst = rst; v.iv = iv; v.iw = iw; v.id = id; v.ordy = ordy; v.byp = byp;
        v.eov = eov; v.ewid = ewid; v.edata = edata; v.eirdy = eirdy; v.ewe = ewe;
        return v;
    endfunction

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    task automatic drv(bit iv, logic [1:0] iw, logic [127:0] id, bit ordy, bit fv, logic [1:0] fw);
        in_valid = iv; in_wid = iw; in_data = id; out_ready = ordy; flush_valid = fv; flush_wid = fw;
    endtask

    task automatic do_reset();
        drv(1'b0, 2'd0, 128'd0, 1'b0, 1'b0, 2'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int w = 0; w < 4; w++) mq[w].delete();
        m_rr = 0;
    endtask

    // Compare DUT against the model for the current inputs, then advance the model.
    task automatic model_step();
        bit           found;
        int           win;
        bit           byp;
        bit           all_empty;
        bit           eirdy;
        bit           eov;
        logic [1:0]   ewid;
        logic [127:0] edata;
        logic [3:0]   ewe;
        found = 1'b0; win = 0; byp = 1'b0; all_empty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int w;
            w = (m_rr + i) % 4;
            if (!found && mq[w].size() > 0 && !(flush_valid && int'(flush_wid) == w)) begin
                found = 1'b1;
                win = w;
            end
        end
        for (int w = 0; w < 4; w++) begin
            ewe[w] = (mq[w].size() == 0);
            if (mq[w].size() != 0) all_empty = 1'b0;
        end
        eirdy = (mq[in_wid].size() < 4) && !(flush_valid && flush_wid == in_wid);
`ifdef IBUF_BYPASS_EN
        byp = all_empty && in_valid && !(flush_valid && flush_wid == in_wid);
`endif
        if (byp) begin
            eov = 1'b1; ewid = in_wid; edata = in_data;
        end else begin
            eov = found; ewid = 2'(win); edata = found ? mq[win][0] : 128'd0;
        end
        chk("m_out_valid", 128'(out_valid), 128'(eov));
        if (eov) begin
            chk("m_out_wid", 128'(out_wid), 128'(ewid));
            chk("m_out_data", out_data, edata);
        end
        chk("m_in_ready", 128'(in_ready), 128'(eirdy));
        chk("m_warp_empty", 128'(warp_empty), 128'(ewe));
        if (byp && out_ready) begin
            m_rr = (int'(in_wid) + 1) % 4;
        end else begin
            if (found && out_ready) begin
                void'(mq[win].pop_front());
                m_rr = (win + 1) % 4;
            end
            if (in_valid && eirdy) mq[in_wid].push_back(in_data);
        end
        if (flush_valid) mq[flush_wid].delete();
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        drv(1'b0, 2'd0, 128'd0, 1'b0, 1'b0, 2'd0);
        do_reset();

        // Reset state.
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_warp_empty", 128'(warp_empty), 128'hF);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        cyc();

        // Fill warp 2 to full, block the fifth push, drain in order.
        tbl.push_back(mk(1, 1, 2'd2, 128'hA0, 0, 1, 0, 2'd0, 128'h0,  1, 4'b1111));
        tbl.push_back(mk(0, 1, 2'd2, 128'hA1, 0, 0, 1, 2'd2, 128'hA0, 1, 4'b1011));
        tbl.push_back(mk(0, 1, 2'd2, 128'hA2, 0, 0, 1, 2'd2, 128'hA0, 1, 4'b1011));
        tbl.push_back(mk(0, 1, 2'd2, 128'hA3, 0, 0, 1, 2'd2, 128'hA0, 1, 4'b1011));
        tbl.push_back(mk(0, 1, 2'd2, 128'hA4, 0, 0, 1, 2'd2, 128'hA0, 0, 4'b1011));
        tbl.push_back(mk(0, 0, 2'd2, 128'h0,  1, 0, 1, 2'd2, 128'hA0, 0, 4'b1011));
        tbl.push_back(mk(0, 0, 2'd2, 128'h0,  1, 0, 1, 2'd2, 128'hA1, 1, 4'b1011));
        tbl.push_back(mk(0, 0, 2'd2, 128'h0,  1, 0, 1, 2'd2, 128'hA2, 1, 4'b1011));
        tbl.push_back(mk(0, 0, 2'd2, 128'h0,  1, 0, 1, 2'd2, 128'hA3, 1, 4'b1011));
        tbl.push_back(mk(0, 0, 2'd2, 128'h0,  1, 0, 0, 2'd0, 128'h0,  1, 4'b1111));
        // Round-robin over warps 0,1,3, then show rr_ptr returned to 0.
        tbl.push_back(mk(1, 1, 2'd0, 128'hB0, 0, 1, 0, 2'd0, 128'h0,  1, 4'b1111));
        tbl.push_back(mk(0, 1, 2'd1, 128'hB1, 0, 0, 1, 2'd0, 128'hB0, 1, 4'b1110));
        tbl.push_back(mk(0, 1, 2'd3, 128'hB3, 0, 0, 1, 2'd0, 128'hB0, 1, 4'b1100));
        tbl.push_back(mk(0, 0, 2'd0, 128'h0,  1, 0, 1, 2'd0, 128'hB0, 1, 4'b0100));
        tbl.push_back(mk(0, 0, 2'd0, 128'h0,  1, 0, 1, 2'd1, 128'hB1, 1, 4'b0101));
        tbl.push_back(mk(0, 0, 2'd0, 128'h0,  1, 0, 1, 2'd3, 128'hB3, 1, 4'b0111));
        tbl.push_back(mk(0, 0, 2'd0, 128'h0,  1, 0, 0, 2'd0, 128'h0,  1, 4'b1111));
        tbl.push_back(mk(0, 1, 2'd3, 128'hC3, 0, 1, 0, 2'd0, 128'h0,  1, 4'b1111));
        tbl.push_back(mk(0, 1, 2'd0, 128'hC0, 0, 0, 1, 2'd3, 128'hC3, 1, 4'b0111));
        tbl.push_back(mk(0, 0, 2'd0, 128'h0,  0, 0, 1, 2'd0, 128'hC0, 1, 4'b0110));
        tbl.push_back(mk(0, 0, 2'd0, 128'h0,  1, 0, 1, 2'd0, 128'hC0, 1, 4'b0110));
        tbl.push_back(mk(0, 0, 2'd0, 128'h0,  1, 0, 1, 2'd3, 128'hC3, 1, 4'b0111));
        tbl.push_back(mk(0, 0, 2'd0, 128'h0,  1, 0, 0, 2'd0, 128'h0,  1, 4'b1111));

        for (int k = 0; k < tbl.size(); k++) begin
            vec_t v;
            v = tbl[k];
            if (v.rst) do_reset();
`ifdef IBUF_BYPASS_EN
            if (v.byp) begin
                v.eov = 1'b1; v.ewid = v.iw; v.edata = v.id;
            end
`endif
            drv(v.iv, v.iw, v.id, v.ordy, 1'b0, 2'd0);
            @(negedge clk);
            chk("tbl_out_valid", 128'(out_valid), 128'(v.eov));
            if (v.eov) begin
                chk("tbl_out_wid", 128'(out_wid), 128'(v.ewid));
                chk("tbl_out_data", out_data, v.edata);
            end
            chk("tbl_in_ready", 128'(in_ready), 128'(v.eirdy));
            chk("tbl_warp_empty", 128'(warp_empty), 128'(v.ewe));
            cyc();
        end

        // Flush of warp 1 blocks a same-cycle push to it; warp 0 still issues.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 2'd1, 128'hE0 + 128'(k), 1'b0, 1'b0, 2'd0);
            @(negedge clk); cyc();
        end
        drv(1'b1, 2'd0, 128'hE3, 1'b0, 1'b0, 2'd0);
        @(negedge clk); cyc();
        drv(1'b1, 2'd1, 128'hE9, 1'b1, 1'b1, 2'd1);
        @(negedge clk);
        chk("flush_in_ready", 128'(in_ready), 128'd0);
        chk("flush_out_valid", 128'(out_valid), 128'd1);
        chk("flush_out_wid", 128'(out_wid), 128'd0);
        chk("flush_out_data", out_data, 128'hE3);
        cyc();
        drv(1'b0, 2'd0, 128'd0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        chk("flush_after_empty", 128'(warp_empty), 128'hF);
        chk("flush_after_valid", 128'(out_valid), 128'd0);
        cyc();

        // Full warp 3: push+pop in the same cycle only pops.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drv(1'b1, 2'd3, 128'hD0 + 128'(k), 1'b0, 1'b0, 2'd0);
            @(negedge clk); cyc();
        end
        drv(1'b1, 2'd3, 128'hD4, 1'b1, 1'b0, 2'd0);
        @(negedge clk);
        chk("full_in_ready", 128'(in_ready), 128'd0);
        chk("full_out_data", out_data, 128'hD0);
        cyc();
        drv(1'b0, 2'd3, 128'd0, 1'b1, 1'b0, 2'd0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("full_out_wid", 128'(out_wid), 128'd3);
            chk("full_drain_data", out_data, 128'hD0 + 128'(k));
            cyc();
        end
        @(negedge clk);
        chk("full_drained_valid", 128'(out_valid), 128'd0);
        chk("full_drained_empty", 128'(warp_empty), 128'hF);
        cyc();

        // Empty-buffer latency (bypass when enabled, one cycle otherwise).
        do_reset();
        drv(1'b1, 2'd1, 128'h55, 1'b1, 1'b0, 2'd0);
        @(negedge clk);
`ifdef IBUF_BYPASS_EN
        chk("lat_same_valid", 128'(out_valid), 128'd1);
        chk("lat_same_wid", 128'(out_wid), 128'd1);
        chk("lat_same_data", out_data, 128'h55);
`else
        chk("lat_same_valid", 128'(out_valid), 128'd0);
`endif
        cyc();
        drv(1'b0, 2'd1, 128'd0, 1'b1, 1'b0, 2'd0);
        @(negedge clk);
`ifdef IBUF_BYPASS_EN
        chk("lat_next_valid", 128'(out_valid), 128'd0);
        chk("lat_next_empty", 128'(warp_empty), 128'hF);
`else
        chk("lat_next_valid", 128'(out_valid), 128'd1);
        chk("lat_next_wid", 128'(out_wid), 128'd1);
        chk("lat_next_data", out_data, 128'h55);
`endif
        cyc();

        // Reset in the middle of traffic drops everything.
        for (int k = 0; k < 6; k++) begin
            drv(1'b1, 2'($urandom_range(0, 3)), 128'($urandom), 1'b0, 1'b0, 2'd0);
            @(negedge clk); cyc();
        end
        do_reset();
        @(negedge clk);
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_warp_empty", 128'(warp_empty), 128'hF);
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        cyc();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int ordy_pct;
            ordy_pct = (n < 1500) ? 35 : 70;
            drv($urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)),
                {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, 99) < ordy_pct,
                $urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)));
            @(negedge clk);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
